// File: rtl/nn_param_pkg.sv
// Shared constants, segment encoding and stream tag for the parameter streamer.
// The address map is derived from the layer dimensions so the bases stay consistent.
package nn_param_pkg;

  localparam int IN_DIM     = 7;
  localparam int HID_DIM    = 128;
  localparam int OUT_DIM    = 3;
  localparam int DATA_W     = 9;
  localparam int FRAC_SHIFT = 4;
  localparam int IDX_W      = 7;

  localparam int W1_BASE = 0;
  localparam int B1_BASE = W1_BASE + IN_DIM * HID_DIM;
  localparam int W2_BASE = B1_BASE + HID_DIM;
  localparam int B2_BASE = W2_BASE + HID_DIM * OUT_DIM;
  localparam int TOTAL   = B2_BASE + OUT_DIM;
  localparam int ADDR_W  = 11;

  typedef enum logic [1:0] {SEG_W1, SEG_B1, SEG_W2, SEG_B2} seg_e;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  typedef struct packed {
    seg_e             seg;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic             seg_last;
    logic             last;
  } stream_tag_t;

  // Bias segments are a single row; weight segments are rows x cols.
  function automatic logic [IDX_W-1:0] seg_rows_m1(input seg_e s);
    case (s)
      SEG_W1:  return IDX_W'(IN_DIM - 1);
      SEG_W2:  return IDX_W'(HID_DIM - 1);
      default: return '0;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] seg_cols_m1(input seg_e s);
    case (s)
      SEG_W1, SEG_B1: return IDX_W'(HID_DIM - 1);
      default:        return IDX_W'(OUT_DIM - 1);
    endcase
  endfunction

endpackage

// File: rtl/nn_skid_fifo2.sv
// Two-entry fall-through FIFO for data plus tag. An incoming word bypasses storage
// when the FIFO is empty and the consumer is ready, so there is no added latency.
module nn_skid_fifo2
  import nn_param_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  stream_tag_t       in_tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output stream_tag_t       out_tag_o,
  output logic [1:0]        count_o
);

  // Handshake: a word moves when out_valid_o && out_ready_i in the same cycle.
  // The input side has no ready; the producer must never push into a full FIFO.
  logic [DATA_W-1:0] data_q [2];
  stream_tag_t       tag_q  [2];
  logic              wr_q, rd_q;
  logic [1:0]        count_q, count_d;
  logic              empty, push, pop;

  assign empty       = (count_q == 2'd0);
  assign out_valid_o = !empty || in_valid_i;
  assign out_data_o  = empty ? in_data_i : data_q[rd_q];
  assign out_tag_o   = empty ? in_tag_i  : tag_q[rd_q];
  assign push        = in_valid_i && !(empty && out_ready_i);
  assign pop         = !empty && out_ready_i;
  assign count_o     = count_q;

  always_comb begin
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_q] <= in_data_i;
        tag_q[wr_q]  <= in_tag_i;
        wr_q         <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/nn_param_streamer.sv
// Walks the parameter RAM in ascending address order, rescales each word and streams
// it with segment/row/column tags. Reads are credit-limited by the output FIFO.
module nn_param_streamer
  import nn_param_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_seg,
  output logic [6:0]        out_row,
  output logic [6:0]        out_col,
  output logic              out_seg_last,
  output logic              out_last,
  output logic [1:0]        dbg_state
);

  state_e            state_q;
  logic              busy_q, done_q;
  logic [ADDR_W-1:0] ptr_q;
  seg_e              seg_q;
  logic [IDX_W-1:0]  row_q, col_q;
  logic              pend_q;
  stream_tag_t       pend_tag_q, cur_tag, fifo_tag, out_tag;
  logic [DATA_W-1:0] scaled, fifo_data;
  logic              fifo_valid, issue, row_end, col_end;
  logic [1:0]        fifo_count;

  always_comb begin
    row_end          = (row_q == seg_rows_m1(seg_q));
    col_end          = (col_q == seg_cols_m1(seg_q));
    cur_tag          = '0;
    cur_tag.seg      = seg_q;
    cur_tag.row      = row_q;
    cur_tag.col      = col_q;
    cur_tag.seg_last = row_end && col_end;
    cur_tag.last     = row_end && col_end && (seg_q == SEG_B2);
  end

  // Credit: free FIFO slots minus the read still in flight must stay positive.
  assign issue     = (state_q == ST_RUN) &&
                     (({1'b0, fifo_count} + {2'b00, pend_q}) < 3'd2);
  assign mem_rd_en = issue;
  assign mem_addr  = ptr_q;
  assign scaled    = mem_rdata << FRAC_SHIFT;

  nn_skid_fifo2 u_fifo (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (pend_q),
    .in_data_i   (scaled),
    .in_tag_i    (pend_tag_q),
    .out_valid_o (fifo_valid),
    .out_ready_i (out_ready),
    .out_data_o  (fifo_data),
    .out_tag_o   (fifo_tag),
    .count_o     (fifo_count)
  );

  assign out_valid    = fifo_valid;
  assign out_data     = fifo_valid ? fifo_data : '0;
  assign out_tag      = fifo_valid ? fifo_tag  : '0;
  assign out_seg      = out_tag.seg;
  assign out_row      = out_tag.row;
  assign out_col      = out_tag.col;
  assign out_seg_last = out_tag.seg_last;
  assign out_last     = out_tag.last;
  assign busy         = busy_q;
  assign done         = done_q;
  assign dbg_state    = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ptr_q      <= '0;
      seg_q      <= SEG_W1;
      row_q      <= '0;
      col_q      <= '0;
      pend_q     <= 1'b0;
      pend_tag_q <= '0;
    end else begin
      pend_q <= issue;
      done_q <= 1'b0;
      if (issue) pend_tag_q <= cur_tag;
      case (state_q)
        ST_IDLE: if (start) begin
          state_q <= ST_RUN;
          busy_q  <= 1'b1;
          ptr_q   <= '0;
          seg_q   <= SEG_W1;
          row_q   <= '0;
          col_q   <= '0;
        end
        ST_RUN: if (issue) begin
          ptr_q <= ptr_q + ADDR_W'(1);
          if (col_end) begin
            col_q <= '0;
            if (row_end) begin
              row_q <= '0;
              seg_q <= seg_e'(seg_q + 2'd1);
            end else begin
              row_q <= row_q + IDX_W'(1);
            end
          end else begin
            col_q <= col_q + IDX_W'(1);
          end
          if (cur_tag.last) state_q <= ST_DRAIN;
        end
        // The final handshake itself ends the pass so done lands one cycle after it.
        ST_DRAIN: if (out_valid && out_ready && out_last) begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_param_streamer.sv
// Bench for nn_param_streamer: RAM model, expected-stream queue built from nested
// segment loops, and scenario tasks for reset, latency, rescale, stalls and control.
module tb_nn_param_streamer;

  localparam int TOT    = 1411;
  localparam int WORD_W = 27;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, mem_rd_en;
  logic [10:0] mem_addr;
  logic [8:0]  mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [8:0]  out_data;
  logic [1:0]  out_seg;
  logic [6:0]  out_row, out_col;
  logic        out_seg_last, out_last;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [8:0]        ram [0:2047];
  logic [WORD_W-1:0] exp_q[$];
  logic [WORD_W-1:0] cap [0:TOT-1];

  nn_param_streamer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_seg(out_seg), .out_row(out_row), .out_col(out_col),
    .out_seg_last(out_seg_last), .out_last(out_last), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

  function automatic logic [WORD_W-1:0] mk(input int a, input int seg, input int row,
                                           input int col, input bit sl, input bit l);
    logic [8:0] v;
    logic [8:0] d;
    v = ram[a];
    d = {v[4:0], 4'b0000};
    return {d, 2'(seg), 7'(row), 7'(col), sl, l};
  endfunction

  task automatic build_expected();
    exp_q.delete();
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 128; j++)
        exp_q.push_back(mk(i*128 + j, 0, i, j, (i == 6 && j == 127), 1'b0));
    for (int k = 0; k < 128; k++)
      exp_q.push_back(mk(896 + k, 1, 0, k, (k == 127), 1'b0));
    for (int i = 0; i < 128; i++)
      for (int j = 0; j < 3; j++)
        exp_q.push_back(mk(1024 + i*3 + j, 2, i, j, (i == 127 && j == 2), 1'b0));
    for (int k = 0; k < 3; k++)
      exp_q.push_back(mk(1408 + k, 3, 0, k, (k == 2), (k == 2)));
  endtask

  // Starts a pass and consumes it; stops early after stop_at accepted words.
  task automatic run_stream(input int ready_pct, input int stop_at, input bit poke_mid,
                            input bit poke_done, output int accepted);
    int cyc, issued, acc;
    bit prev_stall, hs;
    logic [WORD_W-1:0] prev, cur, e;
    build_expected();
    acc = 0; cyc = 0; prev_stall = 0; prev = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || mem_rd_en !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_cycle: busy=%b rd_en=%b valid=%b, required 1 1 0",
               busy, mem_rd_en, out_valid);
    end
    issued = int'(mem_rd_en);
    while (acc < TOT && acc < stop_at && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      out_ready = (int'($urandom_range(0, 99)) < ready_pct);
      start = poke_mid && ($urandom_range(0, 39) == 0);
      #1;
      cur = {out_data, out_seg, out_row, out_col, out_seg_last, out_last};
      hs  = out_valid && out_ready;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || cur !== prev) begin
          errors++;
          $display("FAIL stall_hold: valid=%b word=%h, required 1 %h", out_valid, cur, prev);
        end
      end
      if (ready_pct >= 100) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL no_bubble: word %0d valid=%b, required 1", acc, out_valid);
        end
      end
      checks++;
      if ((issued + int'(mem_rd_en)) - (acc + int'(hs)) > 2) begin
        errors++;
        $display("FAIL credit: outstanding=%0d, required <=2",
                 (issued + int'(mem_rd_en)) - (acc + int'(hs)));
      end
      if (hs) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_word: got %h, required none", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL stream_word %0d: got %h, required %h", acc, cur, e);
          end
        end
        if (acc < TOT) cap[acc] = cur;
        acc++;
      end
      issued += int'(mem_rd_en);
      prev_stall = out_valid && !out_ready;
      prev = cur;
    end
    start = 1'b0;
    accepted = acc;
    if (cyc >= 30000) begin
      checks++; errors++;
      $display("FAIL timeout: accepted %0d words, required %0d", acc, TOT);
    end else if (acc == TOT) begin
      @(negedge clk); #1;
      start = poke_done;
      checks++;
      if (done !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL done_pulse: done=%b busy=%b, required 1 1", done, busy);
      end
      @(negedge clk); #1;
      start = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL done_end: done=%b busy=%b, required 0 0", done, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({busy, done, mem_rd_en, out_valid, out_seg_last, out_last} !== 6'b0 ||
        mem_addr !== 11'd0 || out_data !== 9'd0 || out_seg !== 2'd0 ||
        out_row !== 7'd0 || out_col !== 7'd0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: flags=%b addr=%0d data=%h seg=%0d row=%0d col=%0d st=%0d, required all 0",
               {busy, done, mem_rd_en, out_valid, out_seg_last, out_last},
               mem_addr, out_data, out_seg, out_row, out_col, dbg_state);
    end
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_pass();
    int n;
    repeat (5) @(negedge clk);
    run_stream(100, TOT, 1'b0, 1'b0, n);
    checks++;
    if (n !== TOT || exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_count: got %0d words (%0d left), required %0d", n, exp_q.size(), TOT);
    end
    checks++;
    if (cap[895][17:1] !== {2'd0, 7'd6, 7'd127, 1'b1}) begin
      errors++;
      $display("FAIL w1_end: got %h, required %h", cap[895][17:1], {2'd0, 7'd6, 7'd127, 1'b1});
    end
    checks++;
    if (cap[896][17:2] !== {2'd1, 7'd0, 7'd0}) begin
      errors++;
      $display("FAIL b1_start: got %h, required %h", cap[896][17:2], {2'd1, 7'd0, 7'd0});
    end
    checks++;
    if (cap[1024][17:2] !== {2'd2, 7'd0, 7'd0}) begin
      errors++;
      $display("FAIL w2_start: got %h, required %h", cap[1024][17:2], {2'd2, 7'd0, 7'd0});
    end
    checks++;
    if (cap[1408][17:16] !== 2'd3 || cap[1408][8:2] !== 7'd0) begin
      errors++;
      $display("FAIL b2_start: seg=%0d col=%0d, required 3 0", cap[1408][17:16], cap[1408][8:2]);
    end
    checks++;
    if (cap[1410][1:0] !== 2'b11 || cap[1409][1:0] !== 2'b00) begin
      errors++;
      $display("FAIL last_flags: w1409=%b w1410=%b, required 00 11", cap[1409][1:0], cap[1410][1:0]);
    end
  endtask

  task automatic test_rescale();
    int n;
    ram[0] = 9'h005; ram[1] = 9'h1F1;
    run_stream(100, TOT, 1'b0, 1'b0, n);
    checks++;
    if (cap[0][26:18] !== 9'h050) begin
      errors++;
      $display("FAIL rescale_0: got %h, required 050", cap[0][26:18]);
    end
    checks++;
    if (cap[1][26:18] !== 9'h110) begin
      errors++;
      $display("FAIL rescale_1: got %h, required 110", cap[1][26:18]);
    end
    ram[0] = 9'h000; ram[1] = 9'h001;
  endtask

  task automatic test_backpressure();
    int n;
    run_stream(30, TOT, 1'b1, 1'b0, n);
    checks++;
    if (n !== TOT || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_count: got %0d words (%0d left), required %0d", n, exp_q.size(), TOT);
    end
  endtask

  task automatic test_reset_mid_pass();
    int n;
    bit saw_done;
    run_stream(70, 500, 1'b0, 1'b0, n);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b busy=%b done=%b rd_en=%b, required 0 0 0 0",
               out_valid, busy, done, mem_rd_en);
    end
    saw_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort_quiet: done/busy seen=1, required 0");
    end
    run_stream(100, TOT, 1'b0, 1'b0, n);
    checks++;
    if (n !== TOT) begin
      errors++;
      $display("FAIL restart_count: got %0d, required %0d", n, TOT);
    end
  endtask

  task automatic test_start_on_done();
    int n;
    bit woke;
    run_stream(100, TOT, 1'b0, 1'b1, n);
    woke = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy === 1'b1 || mem_rd_en === 1'b1) woke = 1;
    end
    checks++;
    if (woke) begin
      errors++;
      $display("FAIL start_on_done: pass restarted=1, required 0");
    end
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) ram[a] = 9'(a);
    test_reset();
    test_full_pass();
    test_rescale();
    test_backpressure();
    test_reset_mid_pass();
    test_start_on_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
